axis_bram_trig_writer: RTL and testbench

- Parametrised successor to the plain AXIS-to-BRAM writer: stores an AXI-Stream into BRAM port A as a circular buffer.
- Adds arm/trigger capture: after arming, writes wrap continuously; a trigger freezes the buffer after a programmable number of post-trigger beats.
- Sits between the stream source (counter/ADC path plus width converter) and a BRAM whose port B is read by the PS.
- Status outputs give software the write pointer, trigger location and wrap flag so it can unroll pre- and post-trigger data.

---
 rtl/axis_bram_trig_writer.sv | 121 ++++++++++++
 tb/tb_axis_bram_trig_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_trig_writer.sv
// rtl/axis_bram_trig_writer.sv - AXI-Stream to BRAM circular capture writer with arm/trigger freeze
// Software unrolls the buffer from sts_data, sts_trig_addr and sts_wrapped once sts_state reads DONE.
module axis_bram_trig_writer #(
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int BRAM_DATA_WIDTH  = 64,
  parameter int BRAM_ADDR_WIDTH  = 9
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_data,
  input  logic                         ctrl_arm,
  input  logic                         trig,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_data,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_trig_addr,
  output logic [1:0]                   sts_state,
  output logic                         sts_wrapped,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we
);

  localparam int WE_W = BRAM_DATA_WIDTH / 8;
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE  = BRAM_ADDR_WIDTH'(1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_LAST = {BRAM_ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0] addr;
  logic [BRAM_ADDR_WIDTH-1:0] addr_inc;
  logic [BRAM_ADDR_WIDTH-1:0] trig_addr;
  logic [BRAM_ADDR_WIDTH-1:0] remaining;
  logic                       wrapped;
  logic                       accept;

  assign s_axis_tready = (state == ST_ARMED) || (state == ST_TRIG);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign addr_inc      = addr + ADDR_ONE;

  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = ~aresetn;
  assign bram_porta_addr   = addr;
  assign bram_porta_wrdata = s_axis_tdata;
  assign bram_porta_we     = accept ? {WE_W{1'b1}} : {WE_W{1'b0}};

  assign sts_data      = addr;
  assign sts_trig_addr = trig_addr;
  assign sts_state     = state;
  assign sts_wrapped   = wrapped;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arm wins over everything, including a trigger in the same cycle.
  always_comb begin
    state_nxt = state;
    if (ctrl_arm) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_ARMED: begin
          if (trig) begin
            state_nxt = (cfg_data == '0) ? ST_DONE : ST_TRIG;
          end
        end
        ST_TRIG: begin
          if (accept && (remaining == ADDR_ONE)) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // The trigger-cycle beat is pre-trigger data; only beats after it count down.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr      <= '0;
      trig_addr <= '0;
      remaining <= '0;
      wrapped   <= 1'b0;
    end else if (ctrl_arm) begin
      addr      <= '0;
      trig_addr <= '0;
      wrapped   <= 1'b0;
    end else begin
      if (accept) begin
        addr <= addr_inc;
        if (addr == ADDR_LAST) begin
          wrapped <= 1'b1;
        end
      end
      if ((state == ST_ARMED) && trig) begin
        trig_addr <= accept ? addr_inc : addr;
        remaining <= cfg_data;
      end else if ((state == ST_TRIG) && accept) begin
        remaining <= remaining - ADDR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_axis_bram_trig_writer.sv
// tb/tb_axis_bram_trig_writer.sv - directed table and sequence checks for axis_bram_trig_writer
module tb_axis_bram_trig_writer;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [8:0]  cfg_data;
  logic        ctrl_arm;
  logic        trig;
  logic [8:0]  sts_data;
  logic [8:0]  sts_trig_addr;
  logic [1:0]  sts_state;
  logic        sts_wrapped;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        bram_porta_clk;
  logic        bram_porta_rst;
  logic [8:0]  bram_porta_addr;
  logic [63:0] bram_porta_wrdata;
  logic [7:0]  bram_porta_we;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [63:0] mem [512];

  always #5 clk = ~clk;

  axis_bram_trig_writer #(
    .AXIS_TDATA_WIDTH(64),
    .BRAM_DATA_WIDTH(64),
    .BRAM_ADDR_WIDTH(9)
  ) dut (
    .aclk(clk),
    .aresetn(aresetn),
    .cfg_data(cfg_data),
    .ctrl_arm(ctrl_arm),
    .trig(trig),
    .sts_data(sts_data),
    .sts_trig_addr(sts_trig_addr),
    .sts_state(sts_state),
    .sts_wrapped(sts_wrapped),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .bram_porta_clk(bram_porta_clk),
    .bram_porta_rst(bram_porta_rst),
    .bram_porta_addr(bram_porta_addr),
    .bram_porta_wrdata(bram_porta_wrdata),
    .bram_porta_we(bram_porta_we)
  );

  always @(posedge clk) begin
    if (bram_porta_we == 8'hFF) begin
      mem[bram_porta_addr] <= bram_porta_wrdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic       arm;
    logic       trg;
    logic       tvalid;
    logic [8:0] cfg;
    logic       ready;
    logic       we;
    logic [1:0] st;
    logic [8:0] addr;
    logic [8:0] taddr;
    logic       wrap;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_idle();
    ctrl_arm = 1'b1; trig = 1'b0; s_axis_tvalid = 1'b0;
    tick();
    ctrl_arm = 1'b0;
  endtask

  task automatic beats(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_axis_tdata = 64'(base + i);
      s_axis_tvalid = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    int w0;
    int acc;
    aresetn = 1'b0; cfg_data = '0; ctrl_arm = 1'b0; trig = 1'b0;
    s_axis_tdata = 64'h55; s_axis_tvalid = 1'b1;

    // reset held with tvalid high
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_tready", s_axis_tready, 1'b0);
      chk("rst_we", bram_porta_we, 8'h00);
      chk("rst_state", sts_state, 2'd0);
      chk("rst_addr", sts_data, 9'd0);
    end
    chk("rst_bram_rst", bram_porta_rst, 1'b1);
    aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();

    //          arm   trg   tv    cfg    rdy   we    st    addr   taddr  wrap
    vt[0]  = '{1'b0, 1'b1, 1'b1, 9'd0, 1'b0, 1'b0, 2'd0, 9'd0, 9'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 2'd1, 9'd0, 9'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 9'd0, 1'b1, 1'b1, 2'd1, 9'd1, 9'd0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 2'd1, 9'd1, 9'd0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 9'd0, 1'b1, 1'b1, 2'd1, 9'd2, 9'd0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 9'd2, 1'b1, 1'b1, 2'd2, 9'd3, 9'd3, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 9'd7, 1'b1, 1'b0, 2'd2, 9'd3, 9'd3, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 9'd0, 1'b1, 1'b1, 2'd2, 9'd4, 9'd3, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 9'd0, 1'b1, 1'b1, 2'd3, 9'd5, 9'd3, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 2'd3, 9'd5, 9'd3, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 2'd1, 9'd0, 9'd0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 2'd3, 9'd0, 9'd0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b1, 9'd0, 1'b0, 1'b0, 2'd1, 9'd0, 9'd0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b1, 9'd0, 1'b1, 1'b1, 2'd1, 9'd0, 9'd0, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b1, 9'd0, 1'b1, 1'b1, 2'd3, 9'd1, 9'd1, 1'b0};

    for (int r = 0; r < 15; r++) begin
      ctrl_arm = vt[r].arm; trig = vt[r].trg; s_axis_tvalid = vt[r].tvalid;
      cfg_data = vt[r].cfg; s_axis_tdata = 64'(100 + r);
      #1;
      chk($sformatf("v%0d_tready", r), s_axis_tready, vt[r].ready);
      chk($sformatf("v%0d_we", r), bram_porta_we, vt[r].we ? 8'hFF : 8'h00);
      tick();
      chk($sformatf("v%0d_state", r), sts_state, vt[r].st);
      chk($sformatf("v%0d_addr", r), sts_data, vt[r].addr);
      chk($sformatf("v%0d_taddr", r), sts_trig_addr, vt[r].taddr);
      chk($sformatf("v%0d_wrap", r), sts_wrapped, vt[r].wrap);
    end
    ctrl_arm = 1'b0; trig = 1'b0; s_axis_tvalid = 1'b0;

    // 600 beats without trigger: wrap and overwrite
    arm_idle();
    for (int i = 0; i < 600; i++) begin
      s_axis_tdata = 64'(i);
      s_axis_tvalid = 1'b1;
      tick();
      if (i == 510) chk("wrap_before", sts_wrapped, 1'b0);
      if (i == 511) chk("wrap_after", sts_wrapped, 1'b1);
    end
    s_axis_tvalid = 1'b0;
    #1;
    chk("wrap_state", sts_state, 2'd1);
    chk("wrap_addr", sts_data, 9'd88);
    chk("wrap_mem0", mem[0], 64'd512);
    chk("wrap_mem87", mem[87], 64'd599);
    chk("wrap_mem88", mem[88], 64'd88);
    chk("wrap_mem511", mem[511], 64'd511);

    // 100 pre-trigger beats, trigger on idle cycle, 10 post beats
    arm_idle();
    chk("arm_clears_wrap", sts_wrapped, 1'b0);
    beats(100, 1000);
    trig = 1'b1; cfg_data = 9'd10;
    tick();
    trig = 1'b0;
    chk("n10_state_trig", sts_state, 2'd2);
    chk("n10_taddr", sts_trig_addr, 9'd100);
    w0 = wr_cnt;
    beats(15, 2000);
    #1;
    chk("n10_writes", 32'(wr_cnt - w0), 32'd10);
    chk("n10_addr", sts_data, 9'd110);
    chk("n10_state", sts_state, 2'd3);
    chk("n10_tready", s_axis_tready, 1'b0);
    chk("n10_mem109", mem[109], 64'd2009);
    chk("n10_mem110", mem[110], 64'd110);

    // trigger coincident with beat at 200, N = 0
    arm_idle();
    beats(200, 0);
    s_axis_tdata = 64'hABCD; s_axis_tvalid = 1'b1; trig = 1'b1; cfg_data = 9'd0;
    tick();
    s_axis_tvalid = 1'b0; trig = 1'b0;
    chk("n0_state", sts_state, 2'd3);
    chk("n0_taddr", sts_trig_addr, 9'd201);
    chk("n0_addr", sts_data, 9'd201);
    chk("n0_mem200", mem[200], 64'hABCD);

    // 50% tvalid during TRIGGERED with N = 5
    arm_idle();
    trig = 1'b1; cfg_data = 9'd5;
    tick();
    trig = 1'b0;
    acc = 0;
    for (int j = 0; j < 12; j++) begin
      s_axis_tvalid = (j % 2 == 0);
      s_axis_tdata = 64'(3000 + j);
      #1;
      if (!s_axis_tvalid) chk("n5_idle_we", bram_porta_we, 8'h00);
      if (s_axis_tvalid && acc < 5) acc++;
      tick();
      chk($sformatf("n5_state_%0d", j), sts_state, (acc >= 5) ? 2'd3 : 2'd2);
    end
    s_axis_tvalid = 1'b0;
    chk("n5_addr", sts_data, 9'd5);

    // arm and trig together from DONE
    ctrl_arm = 1'b1; trig = 1'b1;
    tick();
    ctrl_arm = 1'b0; trig = 1'b0;
    chk("armtrig_state", sts_state, 2'd1);
    chk("armtrig_addr", sts_data, 9'd0);
    chk("armtrig_wrap", sts_wrapped, 1'b0);

    // reset mid-TRIGGERED
    trig = 1'b1; cfg_data = 9'd50;
    tick();
    trig = 1'b0;
    beats(3, 4000);
    s_axis_tvalid = 1'b1;
    #1;
    chk("pre_rst_state", sts_state, 2'd2);
    aresetn = 1'b0;
    #1;
    chk("midrst_state", sts_state, 2'd0);
    chk("midrst_we", bram_porta_we, 8'h00);
    chk("midrst_tready", s_axis_tready, 1'b0);
    chk("midrst_addr", sts_data, 9'd0);
    chk("midrst_taddr", sts_trig_addr, 9'd0);
    w0 = wr_cnt;
    tick();
    chk("midrst_nowrite", 32'(wr_cnt - w0), 32'd0);
    aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
